// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage : execute stage of the 5-stage MIPS pipeline.
//
// Logic, shift, arithmetic and jump-link results are produced combinationally
// in the same cycle the decoded operation arrives. DIV/DIVU run on an
// iterative restoring divider that raises stallreq_o until the quotient and
// remainder are ready, then pulses whilo_o for one cycle with HI/LO valid.
//
// Build option: define EX_DIV_EN to include the divider. Without it DIV/DIVU
// behave as NOP (no write, no stall, no HI/LO write).
//
// Ports:
//   clk          pipeline clock
//   rst          synchronous reset, active-low
//   aluop_i      ALU operation code (EXE_*_OP)
//   alusel_i     result class (EXE_RES_*)
//   reg1_i       operand 1 (rs or immediate)
//   reg2_i       operand 2 (rt or immediate)
//   wd_i         destination register address
//   wreg_i       destination write enable
//   link_addr_i  return address for JAL
//   flush_i      abort any in-flight divide
//   wd_o         destination address to EX/MEM and forwarding
//   wreg_o       write enable to EX/MEM and forwarding
//   wdata_o      result to EX/MEM and forwarding
//   whilo_o      HI/LO write enable
//   hi_o         HI value (remainder)
//   lo_o         LO value (quotient)
//   stallreq_o   stall request to pipeline control
// ---------------------------------------------------------------------------
module ex_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] link_addr_i,
   input  logic        flush_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam int DATA_W = 32;

   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
   localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
   localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
   localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
   localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

   function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? -v : v;
   endfunction

   function automatic logic [DATA_W-1:0] f_neg_if(input logic neg,
                                                  input logic [DATA_W-1:0] v);
      return neg ? -v : v;
   endfunction

   logic signed [DATA_W-1:0] w_s1, w_s2;
   logic [DATA_W-1:0] w_sum, w_diff;
   logic [DATA_W-1:0] w_logic, w_shift, w_arith, w_result;
   logic              w_ov, w_is_div, w_wreg;

   assign w_s1     = reg1_i;
   assign w_s2     = reg2_i;
   assign w_sum    = reg1_i + reg2_i;
   assign w_diff   = reg1_i - reg2_i;
   assign w_is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

   // ---- combinational result path (0-cycle) ----
   always_comb begin
      // Signed overflow only matters for the trapping ADD/SUB forms.
      w_ov = 1'b0;
      if (aluop_i == EXE_ADD_OP)
         w_ov = (reg1_i[31] == reg2_i[31]) && (w_sum[31] != reg1_i[31]);
      else if (aluop_i == EXE_SUB_OP)
         w_ov = (reg1_i[31] != reg2_i[31]) && (w_diff[31] != reg1_i[31]);

      w_logic = '0;
      case (aluop_i)
         EXE_AND_OP: w_logic = reg1_i & reg2_i;
         EXE_OR_OP:  w_logic = reg1_i | reg2_i;
         EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
         EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
         default:    w_logic = '0;
      endcase

      w_shift = '0;
      case (aluop_i)
         EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
         EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP: w_shift = w_s2 >>> reg1_i[4:0];
         default:    w_shift = '0;
      endcase

      w_arith = '0;
      case (aluop_i)
         EXE_ADD_OP, EXE_ADDU_OP: w_arith = w_sum;
         EXE_SUB_OP, EXE_SUBU_OP: w_arith = w_diff;
         EXE_SLT_OP:              w_arith = {31'b0, (w_s1 < w_s2)};
         EXE_SLTU_OP:             w_arith = {31'b0, (reg1_i < reg2_i)};
         default:                 w_arith = '0;
      endcase

      w_result = '0;
      case (alusel_i)
         EXE_RES_LOGIC:       w_result = w_logic;
         EXE_RES_SHIFT:       w_result = w_shift;
         EXE_RES_ARITHMETIC:  w_result = w_arith;
         EXE_RES_JUMP_BRANCH: w_result = link_addr_i;
         default:             w_result = '0;
      endcase
   end

   assign w_wreg  = wreg_i & ~w_ov & ~w_is_div;
   assign wd_o    = rst ? wd_i : '0;
   assign wreg_o  = rst & w_wreg;
   assign wdata_o = rst ? w_result : '0;

`ifdef EX_DIV_EN
   localparam int CNT_W = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END} div_state_t;

   div_state_t        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_q, r_rem, r_dvs;
   logic              r_neg_q, r_neg_r;
   logic [DATA_W:0]   w_part, w_dsub;
   logic              w_signed, w_active;

   assign w_signed = (aluop_i == EXE_DIV_OP);
   // Shift the next dividend bit into the partial remainder and trial-subtract.
   assign w_part   = {r_rem, r_q[DATA_W-1]};
   assign w_dsub   = w_part - {1'b0, r_dvs};
   assign w_active = rst & ~flush_i;

   // ---- divider FSM: one quotient bit per cycle ----
   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         r_state <= DIV_FREE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            DIV_FREE: begin
               if (w_is_div) begin
                  if (reg2_i == '0) begin
                     r_state <= DIV_BYZERO;
                  end else begin
                     r_state <= DIV_ON;
                     r_cnt   <= '0;
                     r_q     <= w_signed ? f_abs(reg1_i) : reg1_i;
                     r_dvs   <= w_signed ? f_abs(reg2_i) : reg2_i;
                     r_rem   <= '0;
                     r_neg_q <= w_signed & (reg1_i[31] ^ reg2_i[31]);
                     r_neg_r <= w_signed & reg1_i[31];
                  end
               end
            end
            DIV_BYZERO: begin
               r_state <= DIV_END;
               r_q     <= '0;
               r_rem   <= '0;
               r_neg_q <= 1'b0;
               r_neg_r <= 1'b0;
            end
            DIV_ON: begin
               r_rem <= w_dsub[DATA_W] ? w_part[DATA_W-1:0] : w_dsub[DATA_W-1:0];
               r_q   <= {r_q[DATA_W-2:0], ~w_dsub[DATA_W]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DIV_CYCLES - 1))
                  r_state <= DIV_END;
            end
            DIV_END: r_state <= DIV_FREE;
            default: r_state <= DIV_FREE;
         endcase
      end
   end

   // ---- stall / HI-LO outputs ----
   assign stallreq_o = w_active & (((r_state == DIV_FREE) & w_is_div) |
                                   (r_state == DIV_BYZERO) | (r_state == DIV_ON));
   assign whilo_o    = w_active & (r_state == DIV_END);
   assign lo_o       = whilo_o ? f_neg_if(r_neg_q, r_q)   : '0;
   assign hi_o       = whilo_o ? f_neg_if(r_neg_r, r_rem) : '0;
`else
   logic w_unused;
   assign w_unused   = clk ^ flush_i;
   assign stallreq_o = 1'b0;
   assign whilo_o    = 1'b0;
   assign hi_o       = '0;
   assign lo_o       = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

   localparam int DIVC = 32;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'b0010_0100;
   localparam logic [7:0] OP_OR   = 8'b0010_0101;
   localparam logic [7:0] OP_XOR  = 8'b0010_0110;
   localparam logic [7:0] OP_NOR  = 8'b0010_0111;
   localparam logic [7:0] OP_SLL  = 8'b0111_1100;
   localparam logic [7:0] OP_SRL  = 8'b0000_0010;
   localparam logic [7:0] OP_SRA  = 8'b0000_0011;
   localparam logic [7:0] OP_SLT  = 8'b0010_1010;
   localparam logic [7:0] OP_SLTU = 8'b0010_1011;
   localparam logic [7:0] OP_ADD  = 8'b0010_0000;
   localparam logic [7:0] OP_ADDU = 8'b0010_0001;
   localparam logic [7:0] OP_SUB  = 8'b0010_0010;
   localparam logic [7:0] OP_SUBU = 8'b0010_0011;
   localparam logic [7:0] OP_DIV  = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU = 8'b0001_1011;
   localparam logic [7:0] OP_JAL  = 8'b0101_0000;

   localparam logic [2:0] RS_NOP   = 3'b000;
   localparam logic [2:0] RS_LOGIC = 3'b001;
   localparam logic [2:0] RS_SHIFT = 3'b010;
   localparam logic [2:0] RS_ARITH = 3'b100;
   localparam logic [2:0] RS_JUMP  = 3'b110;
   localparam logic [2:0] RS_BAD   = 3'b111;

   logic        clk = 1'b0;
   logic        rst, wreg_i, flush_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i, link_addr_i;
   logic [4:0]  wd_i;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ex_stage #(.DIV_CYCLES(DIVC)) dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .link_addr_i(link_addr_i), .flush_i(flush_i), .wd_o(wd_o),
      .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o),
      .lo_o(lo_o), .stallreq_o(stallreq_o)
   );

   // Reference: results from plain arithmetic on wide integers.
   task automatic model(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] link, input logic wr,
                        output logic [31:0] ew, output logic ewe, output logic eov);
      longint sa, sb, s;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      eov = 1'b0;
      ew  = 32'h0;
      case (sel)
         RS_LOGIC: case (op)
            OP_AND: ew = a & b;
            OP_OR:  ew = a | b;
            OP_XOR: ew = a ^ b;
            OP_NOR: ew = ~(a | b);
            default: ew = 32'h0;
         endcase
         RS_SHIFT: case (op)
            OP_SLL: ew = b << a[4:0];
            OP_SRL: ew = b >> a[4:0];
            OP_SRA: ew = 32'($signed(b) >>> a[4:0]);
            default: ew = 32'h0;
         endcase
         RS_ARITH: case (op)
            OP_ADD, OP_ADDU: begin
               s = sa + sb; ew = 32'(s);
               eov = (op == OP_ADD) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            OP_SUB, OP_SUBU: begin
               s = sa - sb; ew = 32'(s);
               eov = (op == OP_SUB) && (s > 64'sd2147483647 || s < -64'sd2147483648);
            end
            OP_SLT:  ew = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: ew = (a < b) ? 32'd1 : 32'd0;
            default: ew = 32'h0;
         endcase
         RS_JUMP: ew = link;
         default: ew = 32'h0;
      endcase
      ewe = wr && !eov && (op != OP_DIV) && (op != OP_DIVU);
   endtask

   task automatic comb_case(input string nm, input logic [7:0] op, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wd, input logic wr);
      logic [31:0] ew;
      logic        ewe, eov;
      @(posedge clk); #1;
      rst = 1'b1; flush_i = 1'b0; aluop_i = op; alusel_i = sel;
      reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr; link_addr_i = $urandom;
      model(op, sel, a, b, link_addr_i, wr, ew, ewe, eov);
      @(negedge clk);
      n_total++;
      if (wreg_o !== ewe) $display("FAIL %s wreg_o: got %b want %b", nm, wreg_o, ewe);
      else n_pass++;
      n_total++;
      if (wd_o !== wd) $display("FAIL %s wd_o: got %0d want %0d", nm, wd_o, wd);
      else n_pass++;
      if (!eov) begin
         n_total++;
         if (wdata_o !== ew) $display("FAIL %s wdata_o: got %h want %h (a=%h b=%h op=%h)",
                                      nm, wdata_o, ew, a, b, op);
         else n_pass++;
      end
      n_total++;
      if (stallreq_o !== 1'b0 || whilo_o !== 1'b0)
         $display("FAIL %s stall/whilo: got %b/%b want 0/0", nm, stallreq_o, whilo_o);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0; flush_i = 1'b0; aluop_i = OP_OR; alusel_i = RS_LOGIC;
      reg1_i = 32'h1234_5678; reg2_i = 32'h0F0F_0F0F; wd_i = 5'd9; wreg_i = 1'b1;
      link_addr_i = 32'h0000_0040;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0)
         $display("FAIL reset_outputs: got wd=%0d wreg=%b wdata=%h whilo=%b hi=%h lo=%h stall=%b want all 0",
                  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
      else n_pass++;
      @(posedge clk); #1;
      aluop_i = OP_DIVU; alusel_i = RS_NOP; reg2_i = 32'd3;
      @(negedge clk);
      n_total++;
      if (stallreq_o !== 1'b0) $display("FAIL reset_div_stall: got %b want 0", stallreq_o);
      else n_pass++;
   endtask

   task automatic test_directed();
      comb_case("or",   OP_OR,   RS_LOGIC, 32'h0000_FF00, 32'h00F0_000F, 5'd3, 1'b1);
      comb_case("add_ov", OP_ADD, RS_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd4, 1'b1);
      comb_case("addu", OP_ADDU, RS_ARITH, 32'h7FFF_FFFF, 32'h0000_0001, 5'd4, 1'b1);
      comb_case("sub_ov", OP_SUB, RS_ARITH, 32'h8000_0000, 32'h0000_0001, 5'd5, 1'b1);
      comb_case("slt",  OP_SLT,  RS_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1);
      comb_case("sltu", OP_SLTU, RS_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 1'b1);
      comb_case("sra",  OP_SRA,  RS_SHIFT, 32'h0000_0004, 32'h8000_0010, 5'd7, 1'b1);
      comb_case("jal",  OP_JAL,  RS_JUMP,  32'h0, 32'h0, 5'd31, 1'b1);
      comb_case("nop",  OP_NOP,  RS_NOP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
      comb_case("badsel", OP_OR, RS_BAD,   32'hFFFF_0000, 32'h0000_FFFF, 5'd8, 1'b1);
   endtask

   task automatic test_random_alu();
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] a, b;
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 12))
            0:  begin op = OP_AND;  sel = RS_LOGIC; end
            1:  begin op = OP_OR;   sel = RS_LOGIC; end
            2:  begin op = OP_XOR;  sel = RS_LOGIC; end
            3:  begin op = OP_NOR;  sel = RS_LOGIC; end
            4:  begin op = OP_SLL;  sel = RS_SHIFT; end
            5:  begin op = OP_SRL;  sel = RS_SHIFT; end
            6:  begin op = OP_SRA;  sel = RS_SHIFT; end
            7:  begin op = OP_ADD;  sel = RS_ARITH; end
            8:  begin op = OP_ADDU; sel = RS_ARITH; end
            9:  begin op = OP_SUB;  sel = RS_ARITH; end
            10: begin op = OP_SUBU; sel = RS_ARITH; end
            11: begin op = OP_SLT;  sel = RS_ARITH; end
            default: begin op = OP_SLTU; sel = RS_ARITH; end
         endcase
         a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + 32'($urandom_range(0, 15)) : $urandom;
         comb_case("rand_alu", op, sel, a, b, 5'($urandom), 1'($urandom));
      end
   endtask

`ifdef EX_DIV_EN
   task automatic div_check(input string nm, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      longint      sa, sb;
      int          ns;
      if (b == 32'h0) begin
         eq = 32'h0; er = 32'h0; ns = 2;
      end else if (op == OP_DIVU) begin
         eq = a / b; er = a % b; ns = DIVC + 1;
      end else begin
         sa = longint'($signed(a)); sb = longint'($signed(b));
         eq = 32'(sa / sb); er = 32'(sa % sb); ns = DIVC + 1;
      end
      for (int k = 0; k <= ns; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            rst = 1'b1; flush_i = 1'b0; aluop_i = op; alusel_i = RS_NOP;
            reg1_i = a; reg2_i = b; wd_i = 5'd2; wreg_i = 1'b1;
         end
         @(negedge clk);
         n_total++;
         if (stallreq_o !== (k < ns) || whilo_o !== (k == ns))
            $display("FAIL %s cycle %0d stall/whilo: got %b/%b want %b/%b",
                     nm, k, stallreq_o, whilo_o, (k < ns), (k == ns));
         else n_pass++;
         if (k == 0) begin
            n_total++;
            if (wreg_o !== 1'b0) $display("FAIL %s wreg_o: got %b want 0", nm, wreg_o);
            else n_pass++;
         end
         if (k == ns) begin
            n_total++;
            if (lo_o !== eq || hi_o !== er)
               $display("FAIL %s lo/hi: got %h/%h want %h/%h (a=%h b=%h)", nm, lo_o, hi_o, eq, er, a, b);
            else n_pass++;
         end
      end
   endtask

   task automatic test_div();
      logic [31:0] a, b;
      div_check("divu_100_7", OP_DIVU, 32'd100, 32'd7);
      div_check("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
      div_check("div_by0", OP_DIV, 32'h1234_5678, 32'h0);
      div_check("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      for (int i = 0; i < 6; i++) begin
         a = $urandom; b = $urandom >> $urandom_range(0, 28);
         if (b == 32'h0) b = 32'd5;
         div_check("rand_div", (i % 2 == 0) ? OP_DIV : OP_DIVU, a, b);
      end
   endtask

   task automatic test_abort(input logic use_rst);
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            rst = 1'b1; flush_i = 1'b0; aluop_i = OP_DIVU; alusel_i = RS_NOP;
            reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd1; wreg_i = 1'b1;
         end
         if (k == 10) begin
            if (use_rst) rst = 1'b0;
            else flush_i = 1'b1;
         end
         @(negedge clk);
         n_total++;
         if (stallreq_o !== (k < 10) || whilo_o !== 1'b0)
            $display("FAIL abort%0d cycle %0d stall/whilo: got %b/%b want %b/0",
                     use_rst, k, stallreq_o, whilo_o, (k < 10));
         else n_pass++;
      end
      div_check(use_rst ? "after_rst" : "after_flush", OP_DIVU, 32'd1000, 32'd3);
      @(posedge clk); #1;
      aluop_i = OP_NOP;
      @(negedge clk);
      n_total++;
      if (whilo_o !== 1'b0 || stallreq_o !== 1'b0)
         $display("FAIL post_div_idle stall/whilo: got %b/%b want 0/0", stallreq_o, whilo_o);
      else n_pass++;
   endtask
`else
   task automatic test_div_disabled();
      comb_case("divu_nop", OP_DIVU, RS_NOP, 32'd100, 32'd7, 5'd2, 1'b1);
      comb_case("div_nop",  OP_DIV,  RS_NOP, 32'hFFFF_FFF9, 32'd0, 5'd2, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random_alu();
`ifdef EX_DIV_EN
      test_div();
      test_abort(1'b0);
      test_abort(1'b1);
`else
      test_div_disabled();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
